// File: rtl/mul_serial_pkg.sv
// rtl/mul_serial_pkg.sv - shared types and default sizes for the serial multiplier lane
package mul_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = $clog2(DEF_WIDTH);
   localparam int PWIDTH    = 2 * DEF_WIDTH;

endpackage

// File: rtl/mul_serial_pp.sv
// rtl/mul_serial_pp.sv - combinational partial-product gate for one multiplier bit
module mul_serial_pp
   import mul_serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = $clog2(WIDTH)
) (
   input  logic [DEPTH-1:0]   idx,
   input  logic [WIDTH-1:0]   a_q,
   input  logic [WIDTH-1:0]   b_q,
   output logic [2*WIDTH-1:0] pp
);

   logic [2*WIDTH-1:0] b_ext;

   // Sign-extend the multiplicand, shift to the bit weight, gate by the multiplier bit
   always_comb begin
      b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      pp    = a_q[idx] ? (b_ext << idx) : '0;
   end

endmodule

// File: rtl/mul_serial_ctrl.sv
// rtl/mul_serial_ctrl.sv - handshaked, abortable shift-add sequencer for signed products
module mul_serial_ctrl
   import mul_serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy,
   output logic [DEPTH-1:0]   o_idx
);

   localparam logic [DEPTH-1:0] LAST = DEPTH'(WIDTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic [DEPTH-1:0]   idx_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] pp;
   logic               idx_last;

   assign idx_last = (idx_q == LAST);

   mul_serial_pp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_pp (
      .idx (idx_q),
      .a_q (a_q),
      .b_q (b_q),
      .pp  (pp)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake decode; ready/valid depend only on state
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (idx_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clr) begin
         state_d = IDLE;
      end
   end

   // Operand capture, bit index stepping and accumulation; the MSB carries negative weight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else if (clr) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  acc_q <= '0;
                  idx_q <= '0;
               end
            end
            RUN: begin
               if (idx_last) begin
                  acc_q <= acc_q - pp;
               end else begin
                  acc_q <= acc_q + pp;
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Product is only exposed while it is being offered
   always_comb begin
      out_p = (state_q == DONE) ? acc_q : '0;
   end

   assign o_idx = idx_q;

endmodule
